hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Consumes the per-instruction Tuse/Tnew/A3 code produced by the D-stage decoder, tracks each in-flight destination register and its remaining Tnew through E, M and W, and produces the D-stage stall plus all forwarding-mux selects. It sits beside the datapath and drives PC/D-register enables, E-register bubble insertion and the D, E and M forward muxes.

---
 rtl/hazard_ctrl_pkg.sv | 43 ++++
 rtl/hazard_fwd_sel.sv | 51 +++++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: Tnew/Tuse codes, forward-mux
// select codes, pipeline stage state records and operand Tuse encoders.
package hazard_ctrl_pkg;

  localparam logic [1:0] T_PC      = 2'd0;
  localparam logic [1:0] T_ALU     = 2'd1;
  localparam logic [1:0] T_DM      = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] rt;
  } m_stage_t;

  // Earliest stage in which rs is consumed; several flags set -> smallest wins.
  function automatic logic [1:0] tuse_rs_enc(input logic u0, input logic u1);
    if (u0)      return 2'd0;
    else if (u1) return 2'd1;
    else         return TUSE_NONE;
  endfunction

  // Earliest stage in which rt is consumed; several flags set -> smallest wins.
  function automatic logic [1:0] tuse_rt_enc(input logic u0, input logic u1, input logic u2);
    if (u0)      return 2'd0;
    else if (u1) return 2'd1;
    else if (u2) return 2'd2;
    else         return TUSE_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand hazard resolver. Slot 0 is the youngest producer, slot 2 the
// oldest. The youngest producer whose destination matches the operand decides
// both the stall term and the select; a matching producer that is not ready
// never lets an older one through. Unused slots are tied to a3 = 0.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter logic [1:0] SEL_0 = FWD_E,
  parameter logic [1:0] SEL_1 = FWD_M,
  parameter logic [1:0] SEL_2 = FWD_W
) (
  input  logic [4:0] operand,
  input  logic [1:0] tuse,
  input  logic [4:0] a3_0,
  input  logic [1:0] tnew_0,
  input  logic [4:0] a3_1,
  input  logic [1:0] tnew_1,
  input  logic [4:0] a3_2,
  input  logic [1:0] tnew_2,
  output logic       stall_term,
  output logic [1:0] sel
);

  logic live;
  logic hit_0;
  logic hit_1;
  logic hit_2;

  // Register 0 is never a real dependency.
  assign live  = (operand != 5'd0);
  assign hit_0 = live && (operand == a3_0);
  assign hit_1 = live && (operand == a3_1);
  assign hit_2 = live && (operand == a3_2);

  // Youngest matching producer governs stall and forwarding.
  always_comb begin
    stall_term = 1'b0;
    sel        = FWD_RF;
    if (hit_0) begin
      stall_term = (tnew_0 > tuse);
      if (tnew_0 == T_PC) sel = SEL_0;
    end else if (hit_1) begin
      stall_term = (tnew_1 > tuse);
      if (tnew_1 == T_PC) sel = SEL_1;
    end else if (hit_2) begin
      stall_term = (tnew_2 > tuse);
      if (tnew_2 == T_PC) sel = SEL_2;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: tracks destination and
// remaining Tnew of instructions in E, M and W, raises the D-stage stall and
// drives the D, E and M forward-mux selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             rs_d,
  input  logic [4:0]             rt_d,
  input  logic                   tuse_rs0,
  input  logic                   tuse_rs1,
  input  logic                   tuse_rt0,
  input  logic                   tuse_rt1,
  input  logic                   tuse_rt2,
  input  logic [1:0]             tnew_d,
  input  logic [4:0]             a3_d,
  output logic                   stall,
  output logic [1:0]             fwd_rs_d,
  output logic [1:0]             fwd_rt_d,
  output logic [1:0]             fwd_rs_e,
  output logic [1:0]             fwd_rt_e,
  output logic [1:0]             fwd_rt_m,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Remaining Tnew after one more stage; a ready result stays ready.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    case (t)
      T_DM:    return T_ALU;
      T_ALU:   return T_PC;
      default: return T_PC;
    endcase
  endfunction

  // Stall-cycle counter step that sticks at all-ones.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
    if (&c) return c;
    else    return c + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  e_stage_t   e_st;
  m_stage_t   m_st;
  logic [4:0] a3_w;

  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       stall_rs;
  logic       stall_rt;
  logic       unused_stall_rs_e;
  logic       unused_stall_rt_e;
  logic       unused_stall_rt_m;

  assign tuse_rs = tuse_rs_enc(tuse_rs0, tuse_rs1);
  assign tuse_rt = tuse_rt_enc(tuse_rt0, tuse_rt1, tuse_rt2);

  // D-stage operands: producers in E, M, W.
  hazard_fwd_sel #(.SEL_0(FWD_E), .SEL_1(FWD_M), .SEL_2(FWD_W)) u_rs_d (
    .operand(rs_d), .tuse(tuse_rs),
    .a3_0(e_st.a3), .tnew_0(e_st.tnew),
    .a3_1(m_st.a3), .tnew_1(m_st.tnew),
    .a3_2(a3_w),    .tnew_2(T_PC),
    .stall_term(stall_rs), .sel(fwd_rs_d)
  );

  hazard_fwd_sel #(.SEL_0(FWD_E), .SEL_1(FWD_M), .SEL_2(FWD_W)) u_rt_d (
    .operand(rt_d), .tuse(tuse_rt),
    .a3_0(e_st.a3), .tnew_0(e_st.tnew),
    .a3_1(m_st.a3), .tnew_1(m_st.tnew),
    .a3_2(a3_w),    .tnew_2(T_PC),
    .stall_term(stall_rt), .sel(fwd_rt_d)
  );

  // E-stage operands: producers in M, W. Their stall terms are constant zero.
  hazard_fwd_sel #(.SEL_0(FWD_M), .SEL_1(FWD_W), .SEL_2(FWD_RF)) u_rs_e (
    .operand(e_st.rs), .tuse(TUSE_NONE),
    .a3_0(m_st.a3), .tnew_0(m_st.tnew),
    .a3_1(a3_w),    .tnew_1(T_PC),
    .a3_2(5'd0),    .tnew_2(T_PC),
    .stall_term(unused_stall_rs_e), .sel(fwd_rs_e)
  );

  hazard_fwd_sel #(.SEL_0(FWD_M), .SEL_1(FWD_W), .SEL_2(FWD_RF)) u_rt_e (
    .operand(e_st.rt), .tuse(TUSE_NONE),
    .a3_0(m_st.a3), .tnew_0(m_st.tnew),
    .a3_1(a3_w),    .tnew_1(T_PC),
    .a3_2(5'd0),    .tnew_2(T_PC),
    .stall_term(unused_stall_rt_e), .sel(fwd_rt_e)
  );

  // M-stage store data: producer in W only.
  hazard_fwd_sel #(.SEL_0(FWD_W), .SEL_1(FWD_RF), .SEL_2(FWD_RF)) u_rt_m (
    .operand(m_st.rt), .tuse(TUSE_NONE),
    .a3_0(a3_w), .tnew_0(T_PC),
    .a3_1(5'd0), .tnew_1(T_PC),
    .a3_2(5'd0), .tnew_2(T_PC),
    .stall_term(unused_stall_rt_m), .sel(fwd_rt_m)
  );

  assign stall = stall_rs | stall_rt;

  // ---- D -> E -> M -> W boundary: advance stage state, bubble E on stall ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_st      <= '0;
      m_st      <= '0;
      a3_w      <= 5'd0;
      stall_cnt <= '0;
    end else begin
      if (stall) begin
        e_st      <= '0;
        stall_cnt <= sat_inc(stall_cnt);
      end else begin
        e_st <= '{a3: a3_d, tnew: tnew_d, rs: rs_d, rt: rt_d};
      end
      m_st <= '{a3: e_st.a3, tnew: sat_dec(e_st.tnew), rt: e_st.rt};
      a3_w <= m_st.a3;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
// The stall counter is narrowed to 3 bits so saturation is reachable.
module tb_hazard_ctrl;

  localparam int CW = 3;

  localparam logic [4:0] F_RS0 = 5'b10000;
  localparam logic [4:0] F_RS1 = 5'b01000;
  localparam logic [4:0] F_RT0 = 5'b00100;
  localparam logic [4:0] F_RT1 = 5'b00010;
  localparam logic [4:0] F_RT2 = 5'b00001;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_d, rt_d, a3_d;
  logic          tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2;
  logic [1:0]    tnew_d;
  logic          stall;
  logic [1:0]    fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs0(tuse_rs0), .tuse_rs1(tuse_rs1),
    .tuse_rt0(tuse_rt0), .tuse_rt1(tuse_rt1), .tuse_rt2(tuse_rt2),
    .tnew_d(tnew_d), .a3_d(a3_d),
    .stall(stall),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] fl,
                     input logic [1:0] tn, input logic [4:0] a3);
    rs_d = rs;
    rt_d = rt;
    {tuse_rs0, tuse_rs1, tuse_rt0, tuse_rt1, tuse_rt2} = fl;
    tnew_d = tn;
    a3_d = a3;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd0);
    repeat (3) cyc();
  endtask

  // lw $r then beq $r,$0 held in D until it issues.
  task automatic lw_beq(input logic [4:0] r);
    drv(5'd0, r, F_RS1, 2'd2, r);
    cyc();
    drv(r, 5'd0, F_RS0 | F_RT0, 2'd0, 5'd0);
    cyc();
    cyc();
    cyc();
    flush();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd0);
    check("rst_stall",    32'(stall), 0);
    check("rst_cnt",      32'(stall_cnt), 0);
    check("rst_fwd_rs_d", 32'(fwd_rs_d), 0);
    check("rst_fwd_rt_m", 32'(fwd_rt_m), 0);
    cyc();
    cyc();
    reset = 1'b0;

    // Reset asserted in the middle of a lw -> beq stall
    drv(5'd0, 5'd2, F_RS1, 2'd2, 5'd2);
    check("a_lw_nostall", 32'(stall), 0);
    cyc();
    drv(5'd2, 5'd0, F_RS0 | F_RT0, 2'd0, 5'd0);
    check("a_beq_stall1", 32'(stall), 1);
    check("a_beq_fwd",    32'(fwd_rs_d), 0);
    cyc();
    check("a_beq_stall2", 32'(stall), 1);
    check("a_cnt1",       32'(stall_cnt), 1);
    reset = 1'b1;
    #1;
    check("a_rst_stall",  32'(stall), 0);
    check("a_rst_cnt",    32'(stall_cnt), 0);
    check("a_rst_fwd_d",  32'(fwd_rs_d), 0);
    check("a_rst_fwd_e",  32'(fwd_rs_e), 0);
    cyc();
    reset = 1'b0;
    #1;
    check("a_post_stall", 32'(stall), 0);
    check("a_post_fwd",   32'(fwd_rs_d), 0);
    flush();

    // lw $5 ; beq $5,$0 -> two stall cycles, then W forward
    drv(5'd0, 5'd5, F_RS1, 2'd2, 5'd5);
    cyc();
    drv(5'd5, 5'd0, F_RS0 | F_RT0, 2'd0, 5'd0);
    check("b_stall_c1", 32'(stall), 1);
    cyc();
    check("b_stall_c2", 32'(stall), 1);
    check("b_cnt1",     32'(stall_cnt), 1);
    cyc();
    check("b_released", 32'(stall), 0);
    check("b_fwd_rs_d", 32'(fwd_rs_d), 3);
    check("b_fwd_rt_d", 32'(fwd_rt_d), 0);
    check("b_cnt2",     32'(stall_cnt), 2);
    flush();

    // lw $2 ; addu $3,$2,$4 ; or $9,$3,$0 ; sw $9
    drv(5'd0, 5'd2, F_RS1, 2'd2, 5'd2);
    cyc();
    drv(5'd2, 5'd4, F_RS1 | F_RT1, 2'd1, 5'd3);
    check("c_stall",     32'(stall), 1);
    cyc();
    check("c_released",  32'(stall), 0);
    check("c_fwd_rs_d",  32'(fwd_rs_d), 0);
    check("c_cnt3",      32'(stall_cnt), 3);
    cyc();
    drv(5'd3, 5'd0, F_RS1 | F_RT1, 2'd1, 5'd9);
    check("c_addu_rs_e_w", 32'(fwd_rs_e), 3);
    check("c_addu_rt_e",   32'(fwd_rt_e), 0);
    check("c_or_nostall",  32'(stall), 0);
    check("c_or_fwd_d",    32'(fwd_rs_d), 0);
    cyc();
    drv(5'd0, 5'd9, F_RS1 | F_RT2, 2'd0, 5'd0);
    check("c_or_rs_e_m",   32'(fwd_rs_e), 2);
    check("c_sw_nostall",  32'(stall), 0);
    check("c_sw_fwd_rt_d", 32'(fwd_rt_d), 0);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd0);
    check("c_sw_rt_e_m",   32'(fwd_rt_e), 2);
    cyc();
    check("c_sw_rt_m_w",   32'(fwd_rt_m), 3);
    flush();

    // lw $10 ; sw $10 data -> no stall
    drv(5'd0, 5'd10, F_RS1, 2'd2, 5'd10);
    cyc();
    drv(5'd0, 5'd10, F_RS1 | F_RT2, 2'd0, 5'd0);
    check("l_sw_nostall", 32'(stall), 0);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd0);
    check("l_rt_e_notready", 32'(fwd_rt_e), 0);
    cyc();
    check("l_rt_m_w", 32'(fwd_rt_m), 3);
    flush();

    // ori $6 ; jr $6 -> one stall, then M forward
    drv(5'd0, 5'd6, F_RS1, 2'd1, 5'd6);
    cyc();
    drv(5'd6, 5'd0, F_RS0, 2'd0, 5'd0);
    check("d_stall", 32'(stall), 1);
    cyc();
    check("d_released", 32'(stall), 0);
    check("d_fwd_rs_d", 32'(fwd_rs_d), 2);
    check("d_cnt4",     32'(stall_cnt), 4);
    flush();

    // jal ; jr $31 -> E forward, no stall
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd31);
    cyc();
    drv(5'd31, 5'd0, F_RS0, 2'd0, 5'd0);
    check("e_nostall",  32'(stall), 0);
    check("e_fwd_rs_d", 32'(fwd_rs_d), 1);
    flush();

    // lw $0 ; beq $0,$0 -> register 0 ignored
    drv(5'd0, 5'd0, F_RS1, 2'd2, 5'd0);
    cyc();
    drv(5'd0, 5'd0, F_RS0 | F_RT0, 2'd0, 5'd0);
    check("f_nostall",  32'(stall), 0);
    check("f_fwd_rs_d", 32'(fwd_rs_d), 0);
    check("f_fwd_rt_d", 32'(fwd_rt_d), 0);
    flush();

    // lw $7 ; addu $7 ; addu $8,$7 -> no M fall-through, then M over W
    drv(5'd0, 5'd7, F_RS1, 2'd2, 5'd7);
    cyc();
    drv(5'd0, 5'd0, F_RS1 | F_RT1, 2'd1, 5'd7);
    cyc();
    drv(5'd7, 5'd0, F_RS1 | F_RT1, 2'd1, 5'd8);
    check("g_nostall",  32'(stall), 0);
    check("g_fwd_rs_d", 32'(fwd_rs_d), 0);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd0);
    check("g_fwd_rs_e", 32'(fwd_rs_e), 2);
    flush();

    // Ready $7 in E over not-ready lw $7 in M: E governs stall and select
    drv(5'd0, 5'd7, F_RS1, 2'd2, 5'd7);
    cyc();
    drv(5'd0, 5'd0, 5'd0, 2'd0, 5'd7);
    cyc();
    drv(5'd7, 5'd0, F_RS0 | F_RT0, 2'd0, 5'd0);
    check("h_nostall",  32'(stall), 0);
    check("h_fwd_rs_d", 32'(fwd_rs_d), 1);
    flush();

    // Stall counter saturation at all-ones
    lw_beq(5'd11);
    check("s_cnt6", 32'(stall_cnt), 6);
    lw_beq(5'd12);
    check("s_cnt_sat", 32'(stall_cnt), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
